// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writeback vs. a buffered
// multi-cycle result stream, with a forced-drain guard against starvation.
module wb_port_arbiter #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_regWrite,
    input  logic [ADDR_W-1:0] pipe_rd,
    input  logic [WIDTH-1:0]  pipe_data,
    input  logic              mc_valid,
    output logic              mc_ready,
    input  logic [ADDR_W-1:0] mc_rd,
    input  logic [WIDTH-1:0]  mc_data,
    output logic              pipe_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [WIDTH-1:0]  rf_wdata,
    output logic              mc_pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic {
        S_NORMAL,
        S_FORCE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_rd_mem   [DEPTH];
    logic [WIDTH-1:0]   r_data_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      w_count_next;
    logic [WW-1:0]      r_wait;
    logic [WW-1:0]      w_wait_next;
    logic               w_pipe_req;
    logic               w_push;
    logic               w_gnt_pipe;
    logic               w_gnt_head;

    assign w_pipe_req = pipe_regWrite && (pipe_rd != '0);
    assign mc_ready   = (r_count < CW'(DEPTH));
    // A handshake to x0 completes but leaves nothing to write back.
    assign w_push     = mc_valid && mc_ready && (mc_rd != '0);
    assign mc_pending = (r_count != '0);
    assign pipe_stall = (r_state == S_FORCE);

    always_comb begin
        w_gnt_pipe   = 1'b0;
        w_gnt_head   = 1'b0;
        w_wait_next  = '0;
        w_state_next = S_NORMAL;
        if (r_state == S_FORCE) begin
            w_gnt_head = (r_count != '0);
        end else if (w_pipe_req) begin
            w_gnt_pipe = 1'b1;
        end else begin
            w_gnt_head = (r_count != '0);
        end
        w_count_next = r_count + CW'(w_push) - CW'(w_gnt_head);
        if (r_state == S_NORMAL) begin
            if (w_count_next == '0 || w_gnt_head) begin
                w_wait_next = '0;
            end else if (r_wait == WW'(MAX_WAIT)) begin
                w_wait_next = r_wait;
            end else begin
                w_wait_next = r_wait + WW'(1);
            end
            if (w_wait_next == WW'(MAX_WAIT) ||
                w_count_next == CW'(DEPTH)) begin
                w_state_next = S_FORCE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd_mem[r_wr_ptr]   <= mc_rd;
            r_data_mem[r_wr_ptr] <= mc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_NORMAL;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wait   <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_wait  <= w_wait_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_gnt_head) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            rf_we <= w_gnt_pipe || w_gnt_head;
            if (w_gnt_head) begin
                rf_waddr <= r_rd_mem[r_rd_ptr];
                rf_wdata <= r_data_mem[r_rd_ptr];
            end else if (w_gnt_pipe) begin
                rf_waddr <= pipe_rd;
                rf_wdata <= pipe_data;
            end
        end
    end

endmodule
